// File: rtl/mastermind_solver.sv
// mastermind_solver
//   Codebreaker for 4-digit, 8-symbol Mastermind. Offers the lowest-numbered
//   code consistent with every recorded guess/feedback pair and stops on a
//   4-red reply, on illegal or contradictory feedback, or when the guess
//   budget runs out.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   start           one-cycle pulse; new game from any state (beats fb_valid)
//   guess_valid     guess presented, awaiting feedback
//   guess[11:0]     offered code, digit n at bits [3n-1:3n-3]
//   fb_valid        feedback strobe for the outstanding guess
//   fb_red/fb_white feedback counts (0..4)
//   busy            searching for the next consistent candidate
//   solved / fail   terminal status, held until start or reset
//   guess_count     feedbacks accepted in this game
module mastermind_solver #(
  parameter int MAX_GUESSES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        guess_valid,
  output logic [11:0] guess,
  input  logic        fb_valid,
  input  logic [2:0]  fb_red,
  input  logic [2:0]  fb_white,
  output logic        busy,
  output logic        solved,
  output logic        fail,
  output logic [3:0]  guess_count
);

  localparam int HW = (MAX_GUESSES > 2) ? $clog2(MAX_GUESSES) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SEARCH = 3'd1;
  localparam logic [2:0] S_OFFER  = 3'd2;
  localparam logic [2:0] S_SOLVED = 3'd3;
  localparam logic [2:0] S_FAIL   = 3'd4;

  logic [2:0]    state;
  logic [11:0]   cand;
  logic [11:0]   guess_r;
  logic [HW-1:0] idx;
  logic [HW-1:0] hist_count;
  // One bit wider than the port so the budget compare works at MAX_GUESSES=16
  logic [4:0]    gcnt;

  logic [11:0] hist_g [MAX_GUESSES];
  logic [2:0]  hist_r [MAX_GUESSES];
  logic [2:0]  hist_w [MAX_GUESSES];

  // Score of the current candidate against history[idx]
  logic [11:0] hg;
  logic [2:0]  ca [8];
  logic [2:0]  cb [8];
  logic [2:0]  sc_red;
  logic [2:0]  common;
  logic [2:0]  sc_white;

  always_comb begin
    hg     = hist_g[idx];
    sc_red = '0;
    common = '0;
    for (int unsigned s = 0; s < 8; s++) begin
      ca[s] = '0;
      cb[s] = '0;
    end
    for (int unsigned i = 0; i < 4; i++) begin
      if (cand[3*i +: 3] == hg[3*i +: 3]) sc_red = sc_red + 3'd1;
      ca[cand[3*i +: 3]] = ca[cand[3*i +: 3]] + 3'd1;
      cb[hg[3*i +: 3]]   = cb[hg[3*i +: 3]] + 3'd1;
    end
    for (int unsigned s = 0; s < 8; s++)
      common = common + ((ca[s] < cb[s]) ? ca[s] : cb[s]);
    sc_white = common - sc_red;
  end

  logic fb_illegal;
  logic score_match;

  always_comb begin
    fb_illegal = (fb_red > 3'd4) || (fb_white > 3'd4) ||
                 (({1'b0, fb_red} + {1'b0, fb_white}) > 4'd4) ||
                 ((fb_red == 3'd3) && (fb_white == 3'd1));
    score_match = (sc_red == hist_r[idx]) && (sc_white == hist_w[idx]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cand       <= '0;
      idx        <= '0;
      hist_count <= '0;
      gcnt       <= '0;
      guess_r    <= '0;
    end else if (start) begin
      state      <= S_SEARCH;
      cand       <= '0;
      idx        <= '0;
      hist_count <= '0;
      gcnt       <= '0;
    end else begin
      case (state)
        S_SEARCH: begin
          if (hist_count == '0) begin
            state   <= S_OFFER;
            guess_r <= cand;
          end else if (!score_match) begin
            idx <= '0;
            if (cand == '1) state <= S_FAIL;
            else            cand  <= cand + 12'd1;
          end else if (idx == hist_count - HW'(1)) begin
            state   <= S_OFFER;
            guess_r <= cand;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_OFFER: begin
          if (fb_valid) begin
            gcnt <= gcnt + 5'd1;
            if (fb_illegal)                          state <= S_FAIL;
            else if (fb_red == 3'd4)                 state <= S_SOLVED;
            else if (gcnt + 5'd1 == 5'(MAX_GUESSES)) state <= S_FAIL;
            // The last code was just offered; nothing above it remains
            else if (cand == '1)                     state <= S_FAIL;
            else begin
              hist_g[hist_count] <= cand;
              hist_r[hist_count] <= fb_red;
              hist_w[hist_count] <= fb_white;
              hist_count         <= hist_count + 1'b1;
              cand               <= cand + 12'd1;
              idx                <= '0;
              state              <= S_SEARCH;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign guess       = guess_r;
  assign guess_valid = (state == S_OFFER);
  assign busy        = (state == S_SEARCH);
  assign solved      = (state == S_SOLVED);
  assign fail        = (state == S_FAIL);
  assign guess_count = gcnt[3:0];

endmodule

// File: tb/tb_mastermind_solver.sv
// tb_mastermind_solver
//   Scoreboard bench for mastermind_solver (MAX_GUESSES=16). The driver pushes
//   expected offer/solved/fail events; a monitor pops and compares them when
//   the DUT raises guess_valid, solved or fail.
module tb_mastermind_solver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        guess_valid;
  logic [11:0] guess;
  logic        fb_valid = 1'b0;
  logic [2:0]  fb_red = '0;
  logic [2:0]  fb_white = '0;
  logic        busy;
  logic        solved;
  logic        fail;
  logic [3:0]  guess_count;

  mastermind_solver #(.MAX_GUESSES(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .guess_valid(guess_valid), .guess(guess),
    .fb_valid(fb_valid), .fb_red(fb_red), .fb_white(fb_white),
    .busy(busy), .solved(solved), .fail(fail), .guess_count(guess_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 offer, 1 solved, 2 fail
    logic [11:0] g;
    int          cnt;
  } exp_t;

  exp_t        exp_q [$];
  logic [11:0] seen [$];
  logic [11:0] mh_g [$];
  logic [5:0]  mh_s [$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic push(input int kind, input logic [11:0] g, input int cnt);
    exp_t e;
    e.kind = kind;
    e.g    = g;
    e.cnt  = cnt & 15;
    exp_q.push_back(e);
  endtask

  // Reference scoring by explicit peg pairing
  function automatic logic [5:0] score(input logic [11:0] a, input logic [11:0] b);
    int red = 0;
    int white = 0;
    bit ua [4];
    bit ub [4];
    for (int i = 0; i < 4; i++) begin
      ua[i] = 0; ub[i] = 0;
      if (a[3*i +: 3] == b[3*i +: 3]) begin red++; ua[i] = 1; ub[i] = 1; end
    end
    for (int i = 0; i < 4; i++) begin
      if (!ua[i]) begin
        for (int j = 0; j < 4; j++) begin
          if (!ua[i] && !ub[j] && a[3*i +: 3] == b[3*j +: 3]) begin
            white++; ub[j] = 1; ua[i] = 1;
          end
        end
      end
    end
    return {3'(red), 3'(white)};
  endfunction

  function automatic int next_cons();
    for (int c = 0; c < 4096; c++) begin
      bit ok = 1;
      for (int k = 0; k < mh_g.size(); k++)
        if (score(12'(c), mh_g[k]) != mh_s[k]) ok = 0;
      if (ok) return c;
    end
    return -1;
  endfunction

  // Monitor: compare DUT events against the scoreboard queue
  logic gv_q = 0, sv_q = 0, fl_q = 0;

  task automatic handle(input int kind);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d guess %h count %0d, expected none",
               kind, guess, guess_count);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      if (kind != 2) chk("event_guess", int'(guess), int'(e.g));
      chk("event_count", int'(guess_count), e.cnt);
      if (kind == 0) begin
        int rep = 0;
        foreach (seen[i]) if (seen[i] == guess) rep = 1;
        chk("no_repeat", rep, 0);
        seen.push_back(guess);
      end
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    if (!reset) begin
      if (guess_valid && !gv_q) handle(0);
      if (solved && !sv_q)      handle(1);
      if (fail && !fl_q)        handle(2);
    end
    gv_q = guess_valid;
    sv_q = solved;
    fl_q = fail;
  end

  // Driver helpers (all driving and sampling on the falling edge)
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    seen.delete();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic reply(input logic [2:0] r, input logic [2:0] w);
    fb_valid = 1'b1;
    fb_red   = r;
    fb_white = w;
    @(negedge clk);
    fb_valid = 1'b0;
  endtask

  task automatic wait_offer(input int budget, output bit ok);
    int n = 0;
    ok = 1;
    while (!guess_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!guess_valid) begin
      ok = 0;
      n_tests++;
      n_fail++;
      $display("FAIL offer_timeout: got no guess after %0d cycles, expected a guess", budget);
    end
  endtask

  task automatic wait_drained(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL event_timeout: got %0d pending events, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic play_secret(input logic [11:0] secret);
    logic [11:0] cur;
    logic [5:0]  sc;
    int cnt = 0;
    int nx;
    bit done = 0;
    bit ok;
    mh_g.delete();
    mh_s.delete();
    cur = '0;
    push(0, 12'h000, 0);
    pulse_start();
    for (int step = 0; step < 20 && !done; step++) begin
      wait_offer(30000, ok);
      if (!ok) break;
      sc = score(cur, secret);
      cnt++;
      if (sc[5:3] == 3'd4) begin
        push(1, cur, cnt);
        done = 1;
      end else if (cnt == 16) begin
        push(2, cur, cnt);
        done = 1;
      end else begin
        mh_g.push_back(cur);
        mh_s.push_back(sc);
        nx = next_cons();
        if (nx < 0) begin
          push(2, cur, cnt);
          done = 1;
        end else begin
          push(0, 12'(nx), cnt);
          cur = 12'(nx);
        end
      end
      reply(sc[5:3], sc[2:0]);
    end
    wait_drained(30000);
  endtask

  initial begin
    // Reset, then idle
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outputs", int'({guess, guess_valid, busy, solved, fail, guess_count}), 0);
    end

    // Start latency and a first-guess win
    push(0, 12'h000, 0);
    pulse_start();
    chk("start_busy", int'(busy), 1);
    chk("start_gv_k1", int'(guess_valid), 0);
    @(negedge clk);
    chk("start_gv_k2", int'(guess_valid), 1);
    chk("start_guess", int'(guess), 0);
    push(1, 12'h000, 1);
    reply(3'd4, 3'd0);
    chk("win_solved", int'(solved), 1);
    chk("win_count", int'(guess_count), 1);
    chk("win_gv", int'(guess_valid), 0);
    @(negedge clk);
    reply(3'd0, 3'd0);   // ignored outside OFFER
    repeat (3) @(negedge clk);
    chk("hold_state", int'({solved, fail, guess_valid, busy}), 4'b1000);
    chk("hold_count", int'(guess_count), 1);
    wait_drained(10);

    // Reply 0/0 to 0000: next guess 1111, no guess while searching
    push(0, 12'h000, 0);
    pulse_start();
    wait_drained(10);
    push(0, 12'h249, 1);
    reply(3'd0, 3'd0);
    chk("search_busy", int'(busy), 1);
    chk("search_gv", int'(guess_valid), 0);
    chk("search_count", int'(guess_count), 1);
    wait_drained(2000);

    // start coincident with feedback in OFFER: feedback discarded
    push(0, 12'h000, 0);
    @(negedge clk);
    start = 1'b1;
    seen.delete();
    reply(3'd0, 3'd0);
    start = 1'b0;
    chk("coinc_count", int'(guess_count), 0);
    chk("coinc_busy", int'(busy), 1);
    @(negedge clk);
    chk("coinc_gv", int'(guess_valid), 1);
    chk("coinc_guess", int'(guess), 0);
    wait_drained(10);

    // Reply 1/0 to 0000 gives 0111; 0/0 to that contradicts: exhaustive fail
    push(0, 12'h049, 1);
    reply(3'd1, 3'd0);
    wait_drained(2000);
    push(2, 12'h049, 2);
    reply(3'd0, 3'd0);
    wait_drained(20000);
    chk("contra_fail", int'(fail), 1);
    chk("contra_count", int'(guess_count), 2);
    chk("contra_gv", int'(guess_valid), 0);

    // Illegal reply red=3 white=1
    push(0, 12'h000, 0);
    pulse_start();
    wait_drained(10);
    push(2, 12'h000, 1);
    reply(3'd3, 3'd1);
    chk("illegal_fail", int'(fail), 1);
    chk("illegal_count", int'(guess_count), 1);
    wait_drained(10);

    // start mid-SEARCH clears history
    push(0, 12'h000, 0);
    pulse_start();
    wait_drained(10);
    reply(3'd0, 3'd0);
    repeat (3) @(negedge clk);
    chk("midsearch_busy", int'(busy), 1);
    push(0, 12'h000, 0);
    pulse_start();
    chk("restart_count", int'(guess_count), 0);
    @(negedge clk);
    chk("restart_gv", int'(guess_valid), 1);
    chk("restart_guess", int'(guess), 0);
    wait_drained(10);

    // reset mid-offer
    reset = 1'b1;
    @(negedge clk);
    chk("reset_offer", int'({guess, guess_valid, busy, solved, fail, guess_count}), 0);
    reset = 1'b0;
    @(negedge clk);

    // Full game against secret 7,5,3,1
    play_secret(12'o7531);
    chk("game_solved", int'(solved), 1);
    chk("game_guess", int'(guess), int'(12'o7531));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mastermind_solver.md
# mastermind_solver

Automatic codebreaker for the 4-digit, 8-symbol Mastermind game. It sits on the opposite side of the guess/feedback exchange from the code-holder and comparator: it issues guesses and consumes red/white feedback. Each guess is the lowest-numbered code consistent with every recorded guess and its feedback. It stops on a 4-red result, on contradictory or illegal feedback, or when its guess budget is exhausted.

## Interface
- MAX_GUESSES, 10, history depth and guess budget (2..16).
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; clears history and begins a new game from any state.
- guess_valid  out  1  guess is presented and awaiting feedback.
- guess  out  12  guess code; digit n (n=1..4) at bits [3n-1:3n-3], same packing as code/guess registers.
- fb_valid  in  1  feedback strobe for the outstanding guess.
- fb_red  in  3  count of right symbol, right position (0..4).
- fb_white  in  3  count of right symbol, wrong position (0..4).
- busy  out  1  searching for the next consistent candidate.
- solved  out  1  last guess scored 4 red.
- fail  out  1  no consistent candidate, illegal feedback, or budget exhausted.
- guess_count  out  4  feedbacks accepted in this game, including the winning one.

## Operation
- States: IDLE, SEARCH, OFFER, SOLVED, FAIL.
- Reset: state IDLE; candidate=0, history index=0, hist_count=0.
  - All outputs 0: guess=12'h000, guess_valid, busy, solved, fail, guess_count.
- start is accepted in any state and has priority over fb_valid.
  - Clears hist_count, guess_count, solved and fail.
  - Sets candidate=0 and index=0, then enters SEARCH.
- SEARCH (busy=1): each cycle, score the candidate against history[index].
  - Score mismatch vs stored red/white: candidate+1, index=0.
  - Match with index=hist_count-1, or hist_count=0: candidate is consistent; enter OFFER.
  - Match otherwise: index+1.
  - Candidate 12'hFFF rejected: enter FAIL. There is no wrap-around.
- Scoring (must equal the comparator's Mastermind semantics):
  - red = number of positions with equal digits.
  - white = (sum over symbols 0..7 of min(count in A, count in B)) - red.
  - Results are 3 bits, 0..4.
- A previously offered guess scores 4 red against its own history entry, so it is never re-offered.
- OFFER: guess_valid=1 and guess=candidate, held stable until feedback is accepted. Feedback is accepted on fb_valid=1 while guess_valid=1.
  - guess_count increments on every accepted feedback.
  - Illegal feedback (fb_red>4, fb_white>4, fb_red+fb_white>4, or red=3 with white=1): enter FAIL.
  - fb_red=4: enter SOLVED.
  - Otherwise, if guess_count after increment equals MAX_GUESSES: enter FAIL.
  - Otherwise: append {guess, fb_red, fb_white} at history[hist_count], hist_count+1, candidate+1, index=0; enter SEARCH.
- fb_valid outside OFFER is ignored.
- SOLVED (solved=1) and FAIL (fail=1) hold with guess_valid=0 until start or reset. guess keeps the last offered value.

## Timing
- All outputs are registered and change on the clk edge after the causing event.
- start sampled at edge k:
  - busy=1 from k+1.
  - With empty history, the first guess 12'h000 appears with guess_valid=1 at k+2.
- Feedback accepted at edge k: guess_valid=0 at k+1.
  - SEARCH path: busy=1 at k+1.
  - SOLVED/FAIL path: solved or fail set at k+1.
- Search cost is up to hist_count cycles per candidate. Worst-case latency is at most 4096*(MAX_GUESSES-1) cycles.
- reset mid-search or mid-offer returns everything to reset values on the next edge.
- start during OFFER with a simultaneous fb_valid discards the feedback.

## Test plan
- Reset, then idle 10 cycles: all outputs 0 and state IDLE throughout. Pulse start: guess_valid=1 with guess=12'h000 exactly 2 cycles after start.
- Offer 12'h000 and reply red=4, white=0: solved=1 and guess_count=1 one cycle later; guess_valid=0 and fail=0 until the next start.
- Offer 12'h000 and reply red=0, white=0: next guess is 12'h249 (digits 1,1,1,1); guess_count=1 and no further guess before the search completes.
- Secret digits (d4..d1)=7,5,3,1 with MAX_GUESSES=16, bench scoring with a reference model:
  - Every guess is consistent with all prior feedback.
  - No guess repeats.
  - solved=1 with guess=12'o7531.
- Illegal reply red=3, white=1 to the first guess: fail=1 next cycle and guess_count=1. A contradictory pair of legal replies: fail=1 after exhaustive search, with no wrap-around.
- start pulsed mid-SEARCH and coincident with fb_valid in OFFER: history cleared and guess_count=0; first guess is 12'h000 two cycles later; the coincident feedback is not recorded.
